pwm_generator: RTL and testbench
================================

// Module: pwm_generator
// PURPOSE
//   Free-running, fixed-period PWM generator with a 9-bit duty input and a 1-bit output.
//   Period = 2**CNT_W clock cycles (256 at default).
//   Output is high for min(value, 256) cycles at the start of each period.
//   The duty setting is double-buffered, so a new value takes effect only at a period
//   boundary (glitch-free). Drives LED/motor/DAC filter stages from control logic.
// PARAMETERS
//   CNT_W   8   width of the period counter; period = 2**CNT_W cycles; value width = CNT_W+1
// PORTS
//   clk     in   1        system clock; all logic on rising edge
//   rst     in   1        synchronous, active-high reset
//   value   in   CNT_W+1  requested duty in cycles/period; 0 = off, >= 2**CNT_W = always on
//   pwm     out  1        registered PWM output
// BEHAVIOUR
//   Clock and reset
//     - One clock. Reset is synchronous and active-high.
//     - rst=1 at an edge: cnt<=0, duty_q<=0, pwm<=0. Reset mid-period aborts the period.
//       The first edge after release starts a fresh period at cnt=0.
//   Counter
//     - cnt is CNT_W bits and increments by 1 every non-reset edge.
//     - It wraps from 2**CNT_W-1 to 0 with no idle cycle.
//   Duty saturation
//     - sat = (value >= 2**CNT_W) ? 2**CNT_W : value. This is a CNT_W+1-bit quantity.
//   Duty latch
//     - At an edge where cnt==0, duty_q <= sat.
//     - value is ignored on all other cycles.
//   Output
//     - pwm <= (cnt < duty_now), compared as CNT_W+1-bit unsigned.
//     - duty_now = sat when cnt==0, else duty_q.
//       This makes the sample taken at cnt==0 govern the whole period.
//   Latency
//     - pwm is valid one cycle after the edge that sampled cnt.
//     - In each period, pwm is high for exactly duty cycles, starting at the edge
//       following the cnt==0 edge, then low for 2**CNT_W - duty cycles.
//   Boundary cases
//     - duty 0: pwm constantly 0.
//     - duty 2**CNT_W (value 256..511): pwm constantly 1, with no low cycle at wrap.
//     - duty 1: single-cycle high pulse per period.
//     - value changed mid-period: no effect until the next cnt==0 edge.
//     - value changed on the cnt==0 edge: the new value is used for that period.
//   General
//     - No X propagation from the value input while rst is asserted.
//     - Outputs are only registers; no combinational path from value to pwm.
// STRUCTURE
//   Shared package pwm_pkg
//     - localparam CNT_W default 8.
//     - Function sat_duty(value) returning the CNT_W+1-bit saturated duty.
//   Optional sub-module pwm_period_counter
//     - Ports: clk, rst, cnt[CNT_W-1:0], wrap_start (cnt==0).
//     - Reusable for other timebases.
//   Top level
//     - Holds duty_q, the saturation logic and the output compare register.
// TESTING
//   1. rst=1 for 3 cycles with value=30
//      -> pwm=0 and cnt=0 during reset.
//      After release: pwm high exactly 30 consecutive cycles, then low 226 cycles, repeating.
//   2. value=30, then value=1 written mid-period (cnt=16)
//      -> current period keeps 30 high cycles.
//      Next period: 1 high cycle, then 255 low.
//   3. value=15 held for 5 periods
//      -> each period is exactly 256 cycles with exactly 15 high cycles.
//      The rising edge of pwm lands every 256 cycles.
//   4. value=256, then value=511
//      -> pwm stays 1 continuously across wraps; no low glitch at cnt 255->0.
//   5. value=0
//      -> pwm stays 0 continuously.
//      Then value=255 -> next period is 255 high and 1 low.
//   6. Assert rst mid-period with value=100 (at cnt=50)
//      -> pwm=0 on the following cycle.
//      After release: a full new period of 100 high cycles from cnt=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// ----------------------------------------------------------------------------
// pwm_pkg
//   Shared constants and helpers for the PWM generator.
//   CNT_W     : width of the period counter; one period is 2**CNT_W cycles.
//   DUTY_W    : width of the duty value (CNT_W+1 bits, so "always on" fits).
//   DUTY_FULL : duty value for a fully-on period (2**CNT_W).
//   sat_duty  : clamps a requested duty to DUTY_FULL.
// ----------------------------------------------------------------------------
package pwm_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DUTY_W = CNT_W + 1;

    localparam logic [DUTY_W-1:0] DUTY_FULL = {1'b1, {CNT_W{1'b0}}};

    // Any value with the top bit set is >= 2**CNT_W, so it saturates to full duty.
    function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] value);
        return value[CNT_W] ? DUTY_FULL : value;
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// ----------------------------------------------------------------------------
// pwm_period_counter
//   Free-running wrap-around timebase counter.
//   Ports:
//     i_clk        : clock, rising edge
//     i_rst        : synchronous active-high reset, forces the count to 0
//     o_cnt        : current count, wraps from 2**Width-1 to 0 with no idle cycle
//     o_wrap_start : high while o_cnt == 0 (first cycle of a period)
// ----------------------------------------------------------------------------
module pwm_period_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [Width-1:0] o_cnt,
    output logic             o_wrap_start
);

    logic [Width-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + Width'(1);
        end
    end

    assign o_cnt        = r_cnt;
    assign o_wrap_start = (r_cnt == '0);

endmodule

// File: rtl/pwm_generator.sv
// ----------------------------------------------------------------------------
// pwm_generator
//   Fixed-period PWM generator. Period is 2**CNT_W cycles; the output is high
//   for min(value, 2**CNT_W) cycles at the start of each period. The duty is
//   sampled only at the period boundary, so changes never glitch a period.
//   Ports:
//     i_clk   : clock, rising edge
//     i_rst   : synchronous active-high reset (aborts the current period)
//     i_value : requested duty in cycles per period, CNT_W+1 bits
//     o_pwm   : registered PWM output
// ----------------------------------------------------------------------------
module pwm_generator
    import pwm_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DUTY_W-1:0] i_value,
    output logic              o_pwm
);

    logic [CNT_W-1:0]  w_cnt;
    logic              w_wrap_start;
    logic [DUTY_W-1:0] w_sat;
    logic [DUTY_W-1:0] w_duty_now;
    logic [DUTY_W-1:0] r_duty_q;
    logic              r_pwm;

    pwm_period_counter #(
        .Width (CNT_W)
    ) u_cnt (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_cnt        (w_cnt),
        .o_wrap_start (w_wrap_start)
    );

    assign w_sat = sat_duty(i_value);

    // At the boundary the fresh sample must already drive the compare, otherwise
    // the first cycle of the period would use the previous period's duty.
    assign w_duty_now = w_wrap_start ? w_sat : r_duty_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_duty_q <= '0;
            r_pwm    <= 1'b0;
        end else begin
            if (w_wrap_start) begin
                r_duty_q <= w_sat;
            end
            r_pwm <= ({1'b0, w_cnt} < w_duty_now);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: tb/tb_pwm_generator.sv
// ----------------------------------------------------------------------------
// tb_pwm_generator
//   Directed bench for pwm_generator. Each period is walked cycle by cycle and
//   compared against the hand-derived pattern: high for the expected duty
//   cycles, then low for the rest of the 256-cycle period.
// ----------------------------------------------------------------------------
module tb_pwm_generator;

    logic       clk;
    logic       rst;
    logic [8:0] value;
    logic       pwm;

    int n_checks;
    int n_errors;

    pwm_generator dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_value (value),
        .o_pwm   (pwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks one full period starting at the cnt==0 edge. If chg_at is in range,
    // value is switched to chg_val just before the edge with cnt==chg_at.
    task automatic run_period(input string tag, input int exp_high,
                              input int chg_at, input logic [8:0] chg_val);
        int highs;
        int bad;
        int first_bad;
        highs     = 0;
        bad       = 0;
        first_bad = -1;
        for (int i = 0; i < 256; i++) begin
            if (i == chg_at) value = chg_val;
            step();
            if (pwm === 1'b1) highs++;
            if (pwm !== (i < exp_high)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        check({tag, "_high_count"}, highs, exp_high);
        check({tag, "_pattern_bad_cycles"}, bad, 0);
        if (bad != 0) $display("  %s first deviating cnt %0d", tag, first_bad);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        value    = 9'd30;

        // Test 1: reset holds everything at zero, then 30-high periods repeat.
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_reset_pwm", pwm, 0);
            check("t1_reset_cnt", dut.w_cnt, 0);
        end
        rst = 1'b0;
        run_period("t1_p0", 30, -1, 9'd0);
        run_period("t1_p1", 30, -1, 9'd0);

        // Test 2: mid-period change to 1 only takes effect in the next period.
        run_period("t2_p0", 30, 16, 9'd1);
        run_period("t2_p1", 1, -1, 9'd0);

        // Test 3: value written on the cnt==0 edge applies immediately; 5 periods of 15.
        run_period("t3_p0", 15, 0, 9'd15);
        for (int p = 1; p < 5; p++) run_period("t3_pn", 15, -1, 9'd0);

        // Test 4: saturated duties stay high across wraps.
        run_period("t4_256", 256, 0, 9'd256);
        run_period("t4_chg511", 256, 100, 9'd511);
        run_period("t4_511", 256, -1, 9'd0);

        // Test 5: zero duty, then 255 high / 1 low; change on last cycle is ignored.
        run_period("t5_zero0", 0, 0, 9'd0);
        run_period("t5_zero1", 0, 128, 9'd255);
        run_period("t5_255", 255, 255, 9'd50);
        run_period("t5_50", 50, -1, 9'd0);

        // Test 6: reset at cnt=50 aborts the period; a full new one follows.
        run_period("t6_p0", 100, 0, 9'd100);
        for (int i = 0; i < 50; i++) step();
        check("t6_before_rst_pwm", pwm, 1);
        rst = 1'b1;
        step();
        check("t6_rst_pwm", pwm, 0);
        value = 'x;
        step();
        check("t6_rst_x_pwm", pwm, 0);
        check("t6_rst_cnt", dut.w_cnt, 0);
        value = 9'd100;
        rst   = 1'b0;
        run_period("t6_p1", 100, -1, 9'd0);
        run_period("t6_p2", 100, -1, 9'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
